pipe_mem_access: RTL

//  RV32 memory-access stage between the EX/MEM and MEM/WB boundaries. Consumes the *_M bundle,

---
 rtl/pipe_mem_access.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_mem_access.sv
// RV32 memory-access stage: issues loads/stores on a req/gnt/rvalid bus, aligns and extends
// load data, and registers the stage result into the *_W bundle. Stalls upstream while busy.
module pipe_mem_access #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr_M,
  input  logic        mem_wr_M,
  input  logic        mem_rd_M,
  input  logic [2:0]  mem_mask_M,
  input  logic [1:0]  sel_wb_M,
  input  logic [31:0] alu_o_M,
  input  logic [31:0] wr_data_M,
  input  logic [4:0]  rd_M,
  input  logic [31:0] PC4_M,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        stall_mem,
  output logic        reg_wr_W,
  output logic [1:0]  sel_wb_W,
  output logic [4:0]  rd_W,
  output logic [31:0] alu_o_W,
  output logic [31:0] ld_data_W,
  output logic [31:0] PC4_W,
  output logic        misalign_W,
  output logic        bus_err_W,
  output logic [1:0]  dbg_state
);

  // Bus handshake: a request is presented with dbus_req=1 and all dbus_* fields stable until
  // the cycle dbus_gnt=1 accepts it; exactly one dbus_rvalid later completes it (data or ack).

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        reg_wr_w_q, reg_wr_w_d;
  logic [1:0]  sel_wb_w_q, sel_wb_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic [31:0] alu_o_w_q, alu_o_w_d;
  logic [31:0] ld_data_w_q, ld_data_w_d;
  logic [31:0] pc4_w_q, pc4_w_d;
  logic        misalign_w_q, misalign_w_d;
  logic        bus_err_w_q, bus_err_w_d;

  logic        op;
  logic        illegal;
  logic        timeout_hit;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted;
  logic [31:0] ld_aligned;

  always_comb begin
    op      = mem_rd_M | mem_wr_M;
    illegal = (mem_rd_M & mem_wr_M)
            | (mem_mask_M == 3'b011) | (mem_mask_M == 3'b110) | (mem_mask_M == 3'b111)
            | ((mem_mask_M[1:0] == 2'b01) & alu_o_M[0])
            | ((mem_mask_M[1:0] == 2'b10) & (alu_o_M[1:0] != 2'b00));
    timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);
  end

  // Lane steering: sub-word stores replicate data across the word so the enabled lane is right.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wr_data_M;
    case (mem_mask_M[1:0])
      2'b00: begin
        be_c    = 4'b0001 << alu_o_M[1:0];
        wdata_c = {4{wr_data_M[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {alu_o_M[1], 1'b0};
        wdata_c = {2{wr_data_M[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wr_data_M;
      end
    endcase
  end

  always_comb begin
    shifted    = rdata_q >> {alu_o_M[1:0], 3'b000};
    ld_aligned = rdata_q;
    case (mem_mask_M)
      3'b000:  ld_aligned = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_aligned = {24'h0, shifted[7:0]};
      3'b001:  ld_aligned = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_aligned = {16'h0, shifted[15:0]};
      default: ld_aligned = rdata_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    dbus_req  = 1'b0;
    stall_mem = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op && !illegal) begin
          dbus_req  = 1'b1;
          stall_mem = 1'b1;
          if (dbus_gnt) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
      end
      S_WAIT: begin
        stall_mem = 1'b1;
        if (dbus_rvalid) begin
          rdata_d = mem_rd_M ? dbus_rdata : 32'h0;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Reset releases the pipeline and drops the bus request immediately.
    if (rst) begin
      dbus_req  = 1'b0;
      stall_mem = 1'b0;
    end
  end

  always_comb begin
    dbus_we    = dbus_req & mem_wr_M;
    dbus_addr  = dbus_req ? {alu_o_M[31:2], 2'b00} : 32'h0;
    dbus_be    = dbus_req ? be_c : 4'b0000;
    dbus_wdata = (dbus_req && mem_wr_M) ? wdata_c : 32'h0;
  end

  always_comb begin
    reg_wr_w_d   = 1'b0;
    sel_wb_w_d   = 2'b00;
    rd_w_d       = 5'd0;
    alu_o_w_d    = 32'h0;
    ld_data_w_d  = 32'h0;
    pc4_w_d      = 32'h0;
    misalign_w_d = 1'b0;
    bus_err_w_d  = 1'b0;
    // A stalled cycle leaves the all-zero bubble chosen above.
    if (!stall_mem) begin
      sel_wb_w_d = sel_wb_M;
      rd_w_d     = rd_M;
      alu_o_w_d  = alu_o_M;
      pc4_w_d    = PC4_M;
      if (state_q == S_DONE) begin
        reg_wr_w_d  = reg_wr_M & ~err_q;
        ld_data_w_d = (mem_rd_M && !err_q) ? ld_aligned : 32'h0;
        bus_err_w_d = err_q;
      end else begin
        reg_wr_w_d   = reg_wr_M & ~(op & illegal);
        misalign_w_d = op & illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= 32'h0;
      reg_wr_w_q   <= 1'b0;
      sel_wb_w_q   <= 2'b00;
      rd_w_q       <= 5'd0;
      alu_o_w_q    <= 32'h0;
      ld_data_w_q  <= 32'h0;
      pc4_w_q      <= 32'h0;
      misalign_w_q <= 1'b0;
      bus_err_w_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      reg_wr_w_q   <= reg_wr_w_d;
      sel_wb_w_q   <= sel_wb_w_d;
      rd_w_q       <= rd_w_d;
      alu_o_w_q    <= alu_o_w_d;
      ld_data_w_q  <= ld_data_w_d;
      pc4_w_q      <= pc4_w_d;
      misalign_w_q <= misalign_w_d;
      bus_err_w_q  <= bus_err_w_d;
    end
  end

  assign reg_wr_W   = reg_wr_w_q;
  assign sel_wb_W   = sel_wb_w_q;
  assign rd_W       = rd_w_q;
  assign alu_o_W    = alu_o_w_q;
  assign ld_data_W  = ld_data_w_q;
  assign PC4_W      = pc4_w_q;
  assign misalign_W = misalign_w_q;
  assign bus_err_W  = bus_err_w_q;
  assign dbg_state  = state_q;

endmodule
